// File: rtl/sliced_adder_pkg.sv
// Shared types and helpers for the sliced adder.
// Contains the FSM state encoding and the slice-index width helper.
package sliced_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width needed to count n slices; never narrower than one bit.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/sliced_adder_if.sv
// Request/result handshake bundle for the sliced adder.
// The ovf signal exists only when SLICED_ADDER_OVF_EN is defined.
interface sliced_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             c_out;
`ifdef SLICED_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, A, B, sub, c_in, out_ready,
        input  in_ready, out_valid, S, c_out
`ifdef SLICED_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, A, B, sub, c_in, out_ready,
        output in_ready, out_valid, S, c_out
`ifdef SLICED_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/sliced_adder_slice.sv
// Combinational ripple slice: a chain of full_adder cells.
// c_msb exposes the carry into the top bit so signed overflow can be formed.
module full_adder
    import sliced_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module slice_adder
    import sliced_adder_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             z,
    output logic [SLICE-1:0] s,
    output logic             c,
    output logic             c_msb
);
    logic [SLICE:0] carry_s;

    assign carry_s[0] = z;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (carry_s[i]),
            .s  (s[i]),
            .co (carry_s[i+1])
        );
    end

    assign c     = carry_s[SLICE];
    assign c_msb = carry_s[SLICE-1];
endmodule

// File: rtl/sliced_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, SLICE bits per clock, LSB slice first.
// Optional signed-overflow output enabled by defining SLICED_ADDER_OVF_EN.
module sliced_adder
    import sliced_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    sliced_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = idx_width(NSLICE);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_ZERO = KW'(0);

    state_e           state_r;
    state_e           state_n_s;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic             carry_r;
    logic [WIDTH-1:0] s_r;
    logic             c_out_r;

    logic [SLICE-1:0] x_s;
    logic [SLICE-1:0] y_s;
    logic [SLICE-1:0] sum_s;
    logic             cy_s;
    logic             cy_msb_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             accept_s;
    logic             last_s;

    assign accept_s = bus.start && (state_r == IDLE);
    assign last_s   = (state_r == RUN) && (k_r == K_LAST);

    // Select the operand slice currently being added.
    always_comb begin
        x_s = a_r[k_r*SLICE +: SLICE];
        y_s = b_r[k_r*SLICE +: SLICE];
    end

    slice_adder #(.SLICE(SLICE)) u_slice (
        .x     (x_s),
        .y     (y_s),
        .z     (carry_r),
        .s     (sum_s),
        .c     (cy_s),
        .c_msb (cy_msb_s)
    );

    // Accumulator with the current slice sum merged in at position k.
    always_comb begin
        acc_next_s = acc_r;
        acc_next_s[k_r*SLICE +: SLICE] = sum_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_n_s = RUN;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RUN: begin
                if (k_r == K_LAST) begin
                    state_n_s = DONE;
                end else begin
                    state_n_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = DONE;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Operand latch, slice index, accumulator and inter-slice carry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            k_r     <= K_ZERO;
        end else if (accept_s) begin
            a_r     <= bus.A;
            b_r     <= bus.B ^ {WIDTH{bus.sub}};
            carry_r <= bus.c_in ^ bus.sub;
            k_r     <= K_ZERO;
        end else if (state_r == RUN) begin
            acc_r   <= acc_next_s;
            carry_r <= cy_s;
            if (k_r == K_LAST) begin
                k_r <= K_ZERO;
            end else begin
                k_r <= k_r + K_ONE;
            end
        end
    end

    // Result registers, loaded only at the completion edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s_r     <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
        end else if (last_s) begin
            s_r     <= acc_next_s;
            c_out_r <= cy_s;
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.S         = s_r;
    assign bus.c_out     = c_out_r;

`ifdef SLICED_ADDER_OVF_EN
    logic ovf_r;

    // Signed overflow: carry into MSB differs from carry out of MSB.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_r <= 1'b0;
        end else if (last_s) begin
            ovf_r <= cy_msb_s ^ cy_s;
        end
    end

    assign bus.ovf = ovf_r;
`else
    logic unused_msb_s;
    assign unused_msb_s = cy_msb_s;
`endif

endmodule

// File: tb/tb_sliced_adder.sv
// Directed, table-driven bench for sliced_adder (WIDTH=16, SLICE=4).
// Overflow expectations are checked when SLICED_ADDER_OVF_EN is defined.
module tb_sliced_adder;
    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int NVEC   = 12;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        c_in;
        logic [15:0] s;
        logic        c_out;
        logic        ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    sliced_adder_if #(.WIDTH(WIDTH)) bus ();

    sliced_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request at a negedge and hold it across the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) check("in_ready_timeout", 32'd0, 32'd1);
        bus.A = a;
        bus.B = b;
        bus.sub = sub;
        bus.c_in = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        logic ov_seen;

        bus.start = 1'b0;
        bus.A = 16'h0000;
        bus.B = 16'h0000;
        bus.sub = 1'b0;
        bus.c_in = 1'b0;
        bus.out_ready = 1'b0;

        //            a         b         sub   c_in  s         c_out ovf
        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vecs[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst_S", 32'(bus.S), 32'h0);
        check("rst_c_out", 32'(bus.c_out), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef SLICED_ADDER_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].c_in);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(NSLICE));
            check($sformatf("v%0d_S", i), 32'(bus.S), 32'(vecs[i].s));
            check($sformatf("v%0d_c_out", i), 32'(bus.c_out), 32'(vecs[i].c_out));
`ifdef SLICED_ADDER_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
`endif
            check($sformatf("v%0d_in_ready_busy", i), 32'(bus.in_ready), 32'h0);
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_xfer_valid", i), 32'(bus.out_valid), 32'h0);
            check($sformatf("v%0d_xfer_in_ready", i), 32'(bus.in_ready), 32'h1);
            check($sformatf("v%0d_S_held", i), 32'(bus.S), 32'(vecs[i].s));
            @(negedge clk);
            bus.out_ready = 1'b0;
        end

        // Backpressure: hold DONE for 3 cycles while new requests are offered
        issue(16'hF111, 16'h2222, 1'b0, 1'b0);
        wait_done(lat);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.A = 16'hFFFF;
            bus.B = 16'hFFFF;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_S", j), 32'(bus.S), 32'h1333);
            check($sformatf("bp%0d_c_out", j), 32'(bus.c_out), 32'h1);
            check($sformatf("bp%0d_out_valid", j), 32'(bus.out_valid), 32'h1);
            check($sformatf("bp%0d_in_ready", j), 32'(bus.in_ready), 32'h0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_xfer_valid", 32'(bus.out_valid), 32'h0);
        check("bp_xfer_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp_not_accepted", 32'(bus.in_ready), 32'h1);
        check("bp_S_kept", 32'(bus.S), 32'h1333);

        // Reset during RUN after two slices
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_S", 32'(bus.S), 32'h0);
        check("abort_c_out", 32'(bus.c_out), 32'h0);
        check("abort_out_valid", 32'(bus.out_valid), 32'h0);
        check("abort_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef SLICED_ADDER_OVF_EN
        check("abort_ovf", 32'(bus.ovf), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            ov_seen = ov_seen | bus.out_valid;
        end
        check("abort_no_valid", 32'(ov_seen), 32'h0);
        check("abort_idle", 32'(bus.in_ready), 32'h1);

        // Normal operation after the abort
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        wait_done(lat);
        check("post_latency", 32'(lat), 32'(NSLICE));
        check("post_S", 32'(bus.S), 32'h0100);
        check("post_c_out", 32'(bus.c_out), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
